wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter that shares the register file's single write port between the two pipeline producers that retire results: the ALU stage and the load (memory) stage. It accepts requests on per-source valid/ready handshakes and grants at most one per cycle with two-way round-robin. It drives the register file's `Wen`/`Rd_addr`/`write_data` from registers, suppresses writes to x0, and counts denied-request cycles for performance debug.

## Interface
- `XLEN`, 64, data width; matches the register file.
- `AW`, 5, register address width.
- `CNT_W`, 16, width of the conflict counter.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `alu_valid`  in  1  ALU result pending
- `alu_ready`  out  1  ALU result accepted this cycle
- `alu_rd`  in  AW  ALU destination register
- `alu_data`  in  XLEN  ALU result
- `mem_valid`  in  1  load result pending
- `mem_ready`  out  1  load result accepted this cycle
- `mem_rd`  in  AW  load destination register
- `mem_data`  in  XLEN  load result
- `wen`  out  1  register-file write enable
- `rd_addr`  out  AW  register-file write address
- `write_data`  out  XLEN  register-file write data
- `conflict_cnt`  out  CNT_W  saturating count of cycles where both sources were valid

## Operation
- The priority state machine has two states.
  - `PRI_MEM`: the load source wins if both are valid.
  - `PRI_ALU`: the ALU source wins if both are valid.
- Grant rules:
  - If exactly one source is valid, it is granted regardless of state.
  - If both are valid, the prioritised source is granted.
  - If neither is valid, there is no grant.
- State transitions happen only on a grant:
  - ALU granted → next state `PRI_MEM`.
  - Load granted → next state `PRI_ALU`.
  - No grant → state holds.
- `alu_ready`/`mem_ready` are combinational from the valids and the state.
  - At most one ready is high per cycle.
  - A ready never asserts without its valid.
  - The register file has no backpressure, so the arbiter accepts one request every cycle that any valid is high.
- Handshake: a source holds `valid`, `rd` and `data` stable until its ready is sampled high. An accepted request is consumed on that edge.
- x0 rule: a granted request with `rd==0` is consumed (ready high, state advances) but `wen` stays 0 on the following cycle.
- `conflict_cnt` increments on each cycle where `alu_valid && mem_valid`. It saturates at all-ones; it does not wrap.

## Timing
- Reset values: `wen`=0, `rd_addr`=0, `write_data`=0, `conflict_cnt`=0, state=`PRI_MEM`.
- While `rst`=1, both readies are 0 and nothing is accepted. Requests pending at reset are dropped. Producers re-present them after reset if required.
- Latency: a request accepted at edge N drives `wen`=1 plus `rd_addr`/`write_data` during cycle N+1, for exactly one cycle. `wen` returns to 0 in cycle N+2 unless another grant occurred at edge N+1.
- Throughput: one write per cycle. Back-to-back grants produce continuous `wen`=1 with the output fields updated every cycle.
- Both sources valid and targeting the same `rd`: the write order follows the grant order, so the later write wins in the register file. There is no merging.
- Starvation bound: a continuously valid source waits at most 1 cycle.

## Structure
- Shared package `wb_pkg`:
  - `XLEN`, `AW` constants.
  - Priority state enum `{PRI_MEM, PRI_ALU}`.
  - Source-id encoding `SRC_ALU=0`, `SRC_MEM=1` for debug.
- Sub-module `rr_arb2`: a generic 2-request round-robin grant unit that holds the priority flop and produces a one-hot grant. `wb_arbiter` instantiates it and adds the output registers, the x0 filter and the conflict counter.

## Test plan
- Reset, then single ALU request `rd=5`, `data=64'h1234` → `alu_ready`=1 in cycle 0; `wen`=1, `rd_addr`=5, `write_data`=64'h1234 in cycle 1; `wen`=0 in cycle 2.
- Both sources valid from reset, ALU `rd=3`, load `rd=4`, each held until accepted → load granted first, ALU next cycle. Writes land on x4 then x3. `conflict_cnt`=1.
- Both sources continuously valid for 10 cycles (new data each grant) → grants alternate MEM, ALU, MEM, …; 10 consecutive `wen` pulses; `conflict_cnt`=10.
- ALU request with `rd=0`, `data=64'hFFF` → `alu_ready`=1, `wen` stays 0 next cycle, state becomes `PRI_MEM`.
- Force `conflict_cnt` to near saturation (`CNT_W=4`, 20 dual-valid cycles) → counter holds at 15.
- Assert `rst` for 1 cycle while both sources are valid → readies 0 that cycle, all outputs reset, state `PRI_MEM`; load granted first after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and encodings for the write-back arbiter.
package wb_pkg;

    localparam int XLEN = 64;
    localparam int AW   = 5;

    typedef enum logic {
        PRI_MEM = 1'b0,
        PRI_ALU = 1'b1
    } pri_e;

    // Bit positions in request/grant vectors; also the debug source ids.
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

endpackage

// File: rtl/wb_arbiter_if.sv
// Producer/register-file bundle seen by the write-back arbiter.
interface wb_arbiter_if #(
    parameter int XLEN  = wb_pkg::XLEN,
    parameter int AW    = wb_pkg::AW,
    parameter int CNT_W = 16
);
    logic             alu_valid;
    logic             alu_ready;
    logic [AW-1:0]    alu_rd;
    logic [XLEN-1:0]  alu_data;
    logic             mem_valid;
    logic             mem_ready;
    logic [AW-1:0]    mem_rd;
    logic [XLEN-1:0]  mem_data;
    logic             wen;
    logic [AW-1:0]    rd_addr;
    logic [XLEN-1:0]  write_data;
    logic [CNT_W-1:0] conflict_cnt;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready, wen, rd_addr, write_data, conflict_cnt
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready, wen, rd_addr, write_data, conflict_cnt
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-request round-robin grant unit with a single priority flop.
//   state   | meaning
//   PRI_MEM | request SRC_MEM wins a tie
//   PRI_ALU | request SRC_ALU wins a tie
module rr_arb2
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    pri_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PRI_MEM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        gnt_o   = 2'b00;
        state_d = state_q;
        if (!rst) begin
            if (req_i[SRC_ALU] && req_i[SRC_MEM]) begin
                if (state_q == PRI_ALU) begin
                    gnt_o[SRC_ALU] = 1'b1;
                end else begin
                    gnt_o[SRC_MEM] = 1'b1;
                end
            end else begin
                gnt_o = req_i;
            end
            // The winner yields the next tie to the other source.
            if (gnt_o[SRC_ALU]) begin
                state_d = PRI_MEM;
            end else if (gnt_o[SRC_MEM]) begin
                state_d = PRI_ALU;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Shares the register-file write port between the ALU and load stages;
// registered write outputs, x0 suppression and a saturating conflict counter.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN  = wb_pkg::XLEN,
    parameter int AW    = wb_pkg::AW,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    logic [1:0]       req;
    logic [1:0]       gnt;
    logic [AW-1:0]    sel_rd;
    logic [XLEN-1:0]  sel_data;

    logic             wen_q, wen_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]  write_data_q, write_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign req[SRC_ALU] = bus.alu_valid;
    assign req[SRC_MEM] = bus.mem_valid;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .req_i (req),
        .gnt_o (gnt)
    );

    assign bus.alu_ready    = gnt[SRC_ALU];
    assign bus.mem_ready    = gnt[SRC_MEM];
    assign bus.wen          = wen_q;
    assign bus.rd_addr      = rd_addr_q;
    assign bus.write_data   = write_data_q;
    assign bus.conflict_cnt = cnt_q;

    always_comb begin
        sel_rd   = bus.alu_rd;
        sel_data = bus.alu_data;
        if (gnt[SRC_MEM]) begin
            sel_rd   = bus.mem_rd;
            sel_data = bus.mem_data;
        end

        wen_d        = 1'b0;
        rd_addr_d    = rd_addr_q;
        write_data_d = write_data_q;
        if (|gnt) begin
            // x0 writes are consumed but never reach the register file.
            wen_d        = (sel_rd != '0);
            rd_addr_d    = sel_rd;
            write_data_d = sel_data;
        end

        cnt_d = cnt_q;
        if (bus.alu_valid && bus.mem_valid && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q        <= 1'b0;
            rd_addr_q    <= '0;
            write_data_q <= '0;
            cnt_q        <= '0;
        end else begin
            wen_q        <= wen_d;
            rd_addr_q    <= rd_addr_d;
            write_data_q <= write_data_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised and directed bench for wb_arbiter against a behavioural model.
module tb_wb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.XLEN(64), .AW(5), .CNT_W(16)) bus ();
    wb_arbiter_if #(.XLEN(64), .AW(5), .CNT_W(4))  bus4 ();

    assign bus4.alu_valid = bus.alu_valid;
    assign bus4.alu_rd    = bus.alu_rd;
    assign bus4.alu_data  = bus.alu_data;
    assign bus4.mem_valid = bus.mem_valid;
    assign bus4.mem_rd    = bus.mem_rd;
    assign bus4.mem_data  = bus.mem_data;

    wb_arbiter #(.XLEN(64), .AW(5), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wb_arbiter #(.XLEN(64), .AW(5), .CNT_W(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the source served last loses the next tie.
    bit          m_last_alu = 1'b1;
    bit          m_wen      = 1'b0;
    logic [4:0]  m_rd       = '0;
    logic [63:0] m_data     = '0;
    int          m_conf     = 0;

    // Returns {mem_grant, alu_grant}.
    function automatic logic [1:0] model_grant();
        if (rst) return 2'b00;
        if (bus.alu_valid && bus.mem_valid) return m_last_alu ? 2'b10 : 2'b01;
        return {bus.mem_valid, bus.alu_valid};
    endfunction

    always @(posedge clk) begin
        logic [1:0] g;
        g = model_grant();
        if (rst) begin
            m_last_alu = 1'b1;
            m_wen      = 1'b0;
            m_rd       = '0;
            m_data     = '0;
            m_conf     = 0;
        end else begin
            if (bus.alu_valid && bus.mem_valid) m_conf++;
            m_wen = 1'b0;
            if (g[0]) begin
                m_last_alu = 1'b1;
                m_wen  = (bus.alu_rd != 0);
                m_rd   = bus.alu_rd;
                m_data = bus.alu_data;
            end else if (g[1]) begin
                m_last_alu = 1'b0;
                m_wen  = (bus.mem_rd != 0);
                m_rd   = bus.mem_rd;
                m_data = bus.mem_data;
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] g;
        if (chk_en) begin
            g = model_grant();
            chk("alu_ready", 64'(bus.alu_ready), 64'(g[0]));
            chk("mem_ready", 64'(bus.mem_ready), 64'(g[1]));
            chk("wen", 64'(bus.wen), 64'(m_wen));
            if (m_wen) begin
                chk("rd_addr", 64'(bus.rd_addr), 64'(m_rd));
                chk("write_data", bus.write_data, m_data);
            end
            chk("conflict_cnt16", 64'(bus.conflict_cnt), 64'((m_conf > 65535) ? 65535 : m_conf));
            chk("conflict_cnt4", 64'(bus4.conflict_cnt), 64'((m_conf > 15) ? 15 : m_conf));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input bit v, input logic [4:0] rd, input logic [63:0] d);
        bus.alu_valid = v;
        bus.alu_rd    = rd;
        bus.alu_data  = d;
    endtask

    task automatic set_mem(input bit v, input logic [4:0] rd, input logic [63:0] d);
        bus.mem_valid = v;
        bus.mem_rd    = rd;
        bus.mem_data  = d;
    endtask

    // Two reset edges; valids are left as the caller set them.
    task automatic do_reset();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
        chk("rst_mem_ready", 64'(bus.mem_ready), 64'd0);
        chk("rst_wen", 64'(bus.wen), 64'd0);
        chk("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
        chk("rst_write_data", bus.write_data, 64'd0);
        chk("rst_cnt", 64'(bus.conflict_cnt), 64'd0);
        step();
        rst = 1'b0;
    endtask

    function automatic logic [4:0] rand_rd_nz();
        return 5'($urandom_range(1, 31));
    endfunction

    function automatic logic [63:0] rand_data();
        return {$urandom, $urandom};
    endfunction

    initial begin
        int pulses;
        bit alu_acc, mem_acc;
        set_alu(1'b0, '0, '0);
        set_mem(1'b0, '0, '0);
        @(posedge clk);
        chk_en = 1'b1;
        #1;

        // Single ALU request.
        do_reset();
        set_alu(1'b1, 5'd5, 64'h1234);
        @(negedge clk);
        chk("t1_alu_ready", 64'(bus.alu_ready), 64'd1);
        step();
        set_alu(1'b0, '0, '0);
        @(negedge clk);
        chk("t1_wen", 64'(bus.wen), 64'd1);
        chk("t1_rd_addr", 64'(bus.rd_addr), 64'd5);
        chk("t1_data", bus.write_data, 64'h1234);
        step();
        @(negedge clk);
        chk("t1_wen_drop", 64'(bus.wen), 64'd0);
        step();

        // Both valid through reset; load wins first.
        set_alu(1'b1, 5'd3, 64'hA3);
        set_mem(1'b1, 5'd4, 64'hB4);
        do_reset();
        @(negedge clk);
        chk("t2_mem_first", 64'(bus.mem_ready), 64'd1);
        step();
        set_mem(1'b0, '0, '0);
        @(negedge clk);
        chk("t2_alu_second", 64'(bus.alu_ready), 64'd1);
        chk("t2_rd_x4", 64'(bus.rd_addr), 64'd4);
        step();
        set_alu(1'b0, '0, '0);
        @(negedge clk);
        chk("t2_rd_x3", 64'(bus.rd_addr), 64'd3);
        chk("t2_cnt", 64'(bus.conflict_cnt), 64'd1);
        step();

        // Ten continuous dual-valid cycles alternate MEM, ALU, ...
        set_alu(1'b1, rand_rd_nz(), rand_data());
        set_mem(1'b1, rand_rd_nz(), rand_data());
        do_reset();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_alternate", 64'(bus.mem_ready), 64'((i % 2) == 0));
            if (i > 0 && bus.wen) pulses++;
            step();
            if (i == 9) begin
                set_alu(1'b0, '0, '0);
                set_mem(1'b0, '0, '0);
            end else if ((i % 2) == 0) begin
                set_mem(1'b1, rand_rd_nz(), rand_data());
            end else begin
                set_alu(1'b1, rand_rd_nz(), rand_data());
            end
        end
        @(negedge clk);
        if (bus.wen) pulses++;
        chk("t3_pulses", 64'(pulses), 64'd10);
        chk("t3_cnt", 64'(bus.conflict_cnt), 64'd10);
        step();

        // ALU write to x0 after a load grant.
        do_reset();
        set_mem(1'b1, 5'd7, 64'h77);
        step();
        set_mem(1'b0, '0, '0);
        set_alu(1'b1, 5'd0, 64'hFFF);
        @(negedge clk);
        chk("t4_alu_ready", 64'(bus.alu_ready), 64'd1);
        step();
        set_alu(1'b0, '0, '0);
        @(negedge clk);
        chk("t4_x0_wen", 64'(bus.wen), 64'd0);
        step();
        set_alu(1'b1, 5'd1, 64'h11);
        set_mem(1'b1, 5'd2, 64'h22);
        @(negedge clk);
        chk("t4_pri_mem", 64'(bus.mem_ready), 64'd1);
        step();
        set_alu(1'b0, '0, '0);
        set_mem(1'b0, '0, '0);

        // Saturation of the narrow counter.
        do_reset();
        set_alu(1'b1, 5'd9, 64'h9);
        set_mem(1'b1, 5'd10, 64'hA);
        repeat (20) step();
        set_alu(1'b0, '0, '0);
        set_mem(1'b0, '0, '0);
        @(negedge clk);
        chk("t5_sat4", 64'(bus4.conflict_cnt), 64'd15);
        chk("t5_cnt16", 64'(bus.conflict_cnt), 64'd20);
        step();

        // One-cycle reset mid-run with both sources valid.
        set_alu(1'b1, 5'd11, 64'hB);
        set_mem(1'b1, 5'd12, 64'hC);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_alu_ready", 64'(bus.alu_ready), 64'd0);
        chk("t6_rst_mem_ready", 64'(bus.mem_ready), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_wen", 64'(bus.wen), 64'd0);
        chk("t6_cnt", 64'(bus.conflict_cnt), 64'd0);
        chk("t6_mem_first", 64'(bus.mem_ready), 64'd1);
        step();

        // Random producers obeying the hold-until-accepted handshake.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            alu_acc = bus.alu_ready;
            mem_acc = bus.mem_ready;
            step();
            rst = ($urandom_range(0, 99) == 0);
            if (!bus.alu_valid || alu_acc) begin
                set_alu($urandom_range(0, 2) != 0,
                        ($urandom_range(0, 7) == 0) ? 5'd0 : rand_rd_nz(), rand_data());
            end
            if (!bus.mem_valid || mem_acc) begin
                set_mem($urandom_range(0, 2) != 0,
                        ($urandom_range(0, 7) == 0) ? 5'd0 : rand_rd_nz(), rand_data());
            end
        end
        rst = 1'b0;
        set_alu(1'b0, '0, '0);
        set_mem(1'b0, '0, '0);
        step();
        @(negedge clk);
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
